max_unpool2d_stream: RTL and testbench
======================================

// Module: max_unpool2d_stream
// PURPOSE
//  Streaming inverse of the 2-D max-pool stage, used on the decoder/upsampling path.
//  - Input: pooled activations, each paired with the argmax index of its pooling window.
//  - Output: full-resolution map. Each value is written at its argmax position; other window positions are zero.
//  - Both sides are valid/ready streams in HWC raster order (channel fastest, then column, then row).
//  - One pooled row is buffered, then replayed over POOL_SIZE output rows.
// PARAMETERS
//  IN_WIDTH    16  pooled-map width (output width = IN_WIDTH*POOL_SIZE)
//  IN_HEIGHT   16  pooled-map height (output height = IN_HEIGHT*POOL_SIZE)
//  CHANNELS    16  channels per pixel
//  POOL_SIZE   2   pooling window edge
//  ACTIV_BITS  8   activation width, unsigned
//  IDX_BITS    localparam = $clog2(POOL_SIZE*POOL_SIZE); index encoding is idx = dy*POOL_SIZE + dx
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           reset, asynchronous, active-low
//  in_valid   in   1           input beat valid
//  in_ready   out  1           input beat accepted when in_valid && in_ready
//  in_data    in   ACTIV_BITS  pooled value
//  in_idx     in   IDX_BITS    argmax position of in_data inside its window
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts when out_valid && out_ready
//  out_data   out  ACTIV_BITS  full-resolution element
//  out_last   out  1           high on the final element of a frame
// BEHAVIOUR
//  - Reset: state=S_FILL; all counters 0; out_valid=0, out_data=0, out_last=0.
//  - in_ready = (state==S_FILL), so it reads 1 directly after reset.
//  - S_FILL:
//    - Each accepted beat writes {in_data,in_idx} to row buffer entry px*CHANNELS+c; fill counter increments.
//    - On the IN_WIDTH*CHANNELS-th accept, go to S_EMIT; no beat is lost or duplicated.
//  - S_EMIT:
//    - in_ready=0.
//    - Nested counters, outer to inner: dy (0..P-1), px, dx (0..P-1), c.
//    - Output register loads when !out_valid || out_ready.
//    - Loaded value: out_data = (buf.idx == dy*P+dx) ? buf.val : 0, with buf = buffer[px*CHANNELS+c].
//  - Latency: the first output beat of a row is valid one cycle after the last fill accept.
//  - Backpressure: out_data/out_last hold stable while out_valid && !out_ready.
//  - Row end: when the last element of the row group is loaded into the output register, state returns to S_FILL the next cycle.
//    - The buffer may then be overwritten; the output register keeps its own copy.
//    - py increments at the same point.
//  - Frame end:
//    - out_last=1 on the element with py=IN_HEIGHT-1, dy=P-1, px=IN_WIDTH-1, dx=P-1, c=CHANNELS-1.
//    - py wraps to 0; the next frame starts with no gap.
//  - Out-of-range idx (idx >= P*P, e.g. P=3): no position matches, so the whole window outputs zeros. No error flag.
//  - Reset mid-operation: any state or partial row is abandoned; the next accepted beat is element 0 of a new frame.
//  - Throughput: one output beat per cycle in S_EMIT while out_ready=1. Input is stalled for P*P*IN_WIDTH*CHANNELS cycles per row.
// CONFIGURATION
//  MAX_UNPOOL_NEAREST_EN
//   - Defined: in_idx is ignored and every window position outputs buf.val (nearest-neighbour upsample).
//   - Undefined: argmax placement with zeros elsewhere, as above.
//   - Port list is identical in both builds.
// TESTING  (IN_WIDTH=2, IN_HEIGHT=2, CHANNELS=1, POOL_SIZE=2, ACTIV_BITS=8 unless noted)
//  1. Row {0x10,idx0},{0x20,idx3}, out_ready=1 -> row0: 10,00,00,00; row1: 00,00,00,20.
//  2. Same as 1 with out_ready toggling randomly -> identical 8-beat sequence; out_data stable while stalled.
//  3. in_valid held high during S_EMIT -> in_ready=0, no accept; the next row is accepted only after the 8th output beat is loaded.
//  4. Full frame of 4 input beats -> 16 output beats; out_last only on beat 16. A second frame follows with correct data.
//  5. rst_n pulsed low after 3 output beats -> out_valid=0 asynchronously, in_ready=1. A new frame produces correct output.
//  6. MAX_UNPOOL_NEAREST_EN defined, {0x10,idx2},{0x20,idx1} -> row0: 10,10,20,20; row1: 10,10,20,20.
//  7. CHANNELS=2, POOL_SIZE=3, {0xAA,idx4},{0xBB,idx9} (px=0, c=0/1) -> c0 has 0xAA at centre only; c1 all zero.

Source files
------------

// File: rtl/max_unpool2d_stream.sv
// max_unpool2d_stream: streaming 2-D max-unpool (inverse of max-pool).
// Buffers one pooled row of {value, argmax index} pairs, then replays it over
// POOL_SIZE output rows in HWC raster order, placing each value at its argmax
// position and zero elsewhere.
// Build option: define MAX_UNPOOL_NEAREST_EN to ignore in_idx and replicate the
// value over the whole window (nearest-neighbour upsample).
module max_unpool2d_stream #(
   parameter int IN_WIDTH   = 16,
   parameter int IN_HEIGHT  = 16,
   parameter int CHANNELS   = 16,
   parameter int POOL_SIZE  = 2,
   parameter int ACTIV_BITS = 8,
   localparam int IDX_BITS  = (POOL_SIZE * POOL_SIZE > 1) ? $clog2(POOL_SIZE * POOL_SIZE) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ACTIV_BITS-1:0] in_data,
   input  logic [IDX_BITS-1:0]   in_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACTIV_BITS-1:0] out_data,
   output logic                  out_last
);

   localparam int ROW_N = IN_WIDTH * CHANNELS;
   localparam int AW    = (ROW_N > 1)     ? $clog2(ROW_N)     : 1;
   localparam int XW    = (IN_WIDTH > 1)  ? $clog2(IN_WIDTH)  : 1;
   localparam int YW    = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
   localparam int CW    = (CHANNELS > 1)  ? $clog2(CHANNELS)  : 1;
   localparam int PW    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
   localparam int WW    = ACTIV_BITS + IDX_BITS;

   localparam logic [0:0] S_FILL = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [AW-1:0]         fill_q, fill_d;
   logic [PW-1:0]         dy_q, dy_d, dx_q, dx_d;
   logic [XW-1:0]         px_q, px_d;
   logic [CW-1:0]         c_q, c_d;
   logic [YW-1:0]         py_q, py_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [ACTIV_BITS-1:0] out_data_q, out_data_d;

   logic [WW-1:0]         row_mem [ROW_N];
   logic                  wr_en;
   logic [AW-1:0]         rd_addr;
   logic [WW-1:0]         rd_word;
   logic [ACTIV_BITS-1:0] rd_val;
   logic [IDX_BITS-1:0]   rd_idx;
   logic [31:0]           win_pos;
   logic                  keep;
   logic                  load;
   logic                  c_end, dx_end, px_end, dy_end, py_end, row_end, fill_end;

   assign in_ready  = (state_q == S_FILL);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   assign rd_addr = AW'(32'(px_q) * 32'(CHANNELS) + 32'(c_q));
   assign rd_word = row_mem[rd_addr];
   assign rd_val  = rd_word[WW-1:IDX_BITS];
   assign rd_idx  = rd_word[IDX_BITS-1:0];
   assign win_pos = 32'(dy_q) * 32'(POOL_SIZE) + 32'(dx_q);

   assign c_end    = (c_q == CW'(CHANNELS - 1));
   assign dx_end   = (dx_q == PW'(POOL_SIZE - 1));
   assign px_end   = (px_q == XW'(IN_WIDTH - 1));
   assign dy_end   = (dy_q == PW'(POOL_SIZE - 1));
   assign py_end   = (py_q == YW'(IN_HEIGHT - 1));
   assign row_end  = c_end && dx_end && px_end && dy_end;
   assign fill_end = (fill_q == AW'(ROW_N - 1));
   assign load     = (state_q == S_EMIT) && (!out_valid_q || out_ready);

   // Row buffer write; storage only, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) row_mem[fill_q] <= {in_data, in_idx};
   end

   // Next-state: row fill, replay counters and output register.
   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      dy_d        = dy_q;
      dx_d        = dx_q;
      px_d        = px_q;
      c_d         = c_q;
      py_d        = py_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      wr_en       = 1'b0;
`ifdef MAX_UNPOOL_NEAREST_EN
      keep        = 1'b1;
`else
      // Out-of-range indices never match any window position.
      keep        = (32'(rd_idx) == win_pos);
`endif

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (fill_end) begin
                  fill_d  = '0;
                  state_d = S_EMIT;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
         end
         default: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = keep ? rd_val : '0;
               out_last_d  = row_end && py_end;
               // Odometer: c fastest, then dx, px, dy.
               if (!c_end) begin
                  c_d = c_q + 1'b1;
               end else begin
                  c_d = '0;
                  if (!dx_end) begin
                     dx_d = dx_q + 1'b1;
                  end else begin
                     dx_d = '0;
                     if (!px_end) begin
                        px_d = px_q + 1'b1;
                     end else begin
                        px_d = '0;
                        dy_d = dy_end ? '0 : dy_q + 1'b1;
                     end
                  end
               end
               if (row_end) begin
                  state_d = S_FILL;
                  py_d    = py_end ? '0 : py_q + 1'b1;
               end
            end
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         fill_q      <= '0;
         dy_q        <= '0;
         dx_q        <= '0;
         px_q        <= '0;
         c_q         <= '0;
         py_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         dy_q        <= dy_d;
         dx_q        <= dx_d;
         px_q        <= px_d;
         c_q         <= c_d;
         py_q        <= py_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_max_unpool2d_stream.sv
// Directed bench for max_unpool2d_stream: 2x2 map, 1 channel, 2x2 pool on dut,
// plus a 2-channel 3x3-pool instance for out-of-range index handling.
module tb_max_unpool2d_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0] in_data, out_data;
   logic [1:0] in_idx;
   logic       in_valid7, in_ready7, out_valid7, out_last7;
   logic [7:0] in_data7, out_data7;
   logic [3:0] in_idx7;

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] q [$];
   logic [8:0] q7 [$];
   logic       stall_q = 1'b0;
   logic [8:0] stall_word;

`ifdef MAX_UNPOOL_NEAREST_EN
   localparam logic [63:0] E_R0 = 64'h10_10_20_20_10_10_20_20;
   localparam logic [63:0] E_R1 = 64'h30_30_40_40_30_30_40_40;
   localparam logic [63:0] E_R6 = 64'h10_10_20_20_10_10_20_20;
`else
   localparam logic [63:0] E_R0 = 64'h10_00_00_00_00_00_00_20;
   localparam logic [63:0] E_R1 = 64'h00_30_00_00_00_00_40_00;
   localparam logic [63:0] E_R6 = 64'h00_00_00_20_10_00_00_00;
`endif

   always #5 clk = ~clk;

   max_unpool2d_stream #(
      .IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(1), .POOL_SIZE(2), .ACTIV_BITS(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   max_unpool2d_stream #(
      .IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(2), .POOL_SIZE(3), .ACTIV_BITS(8)
   ) dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
      .in_data(in_data7), .in_idx(in_idx7), .out_valid(out_valid7),
      .out_ready(1'b1), .out_data(out_data7), .out_last(out_last7)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge; also checks hold-while-stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_word", 32'({out_last, out_data}), 32'(stall_word));
         end
         if (out_valid && out_ready) q.push_back({out_last, out_data});
         if (out_valid7) q7.push_back({out_last7, out_data7});
         stall_q    = out_valid && !out_ready;
         stall_word = {out_last, out_data};
      end
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_valid7 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      q7.delete();
   endtask

   task automatic send(input int sel, input logic [7:0] d, input logic [3:0] i);
      logic rdy;
      rdy = 1'b0;
      if (sel == 0) begin
         in_valid = 1'b1; in_data = d; in_idx = i[1:0];
      end else begin
         in_valid7 = 1'b1; in_data7 = d; in_idx7 = i;
      end
      for (int n = 0; n < 500 && !rdy; n++) begin
         @(negedge clk);
         rdy = (sel == 0) ? in_ready : in_ready7;
      end
      if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid7 = 1'b0;
   endtask

   task automatic wait_q(input int n);
      for (int i = 0; i < 2000 && q.size() < n; i++) @(negedge clk);
      if (q.size() < n) chk("wait_timeout", 32'(q.size()), 32'(n));
   endtask

   // Compare 8 captured beats from q[base] against a byte string; last_k = beat with out_last.
   task automatic check_row(input string tag, input int base, input logic [63:0] exp, input int last_k);
      logic [8:0] w;
      for (int k = 0; k < 8; k++) begin
         w = (base + k < q.size()) ? q[base + k] : 9'h1FF;
         chk($sformatf("%s_d%0d", tag, base + k), 32'(w[7:0]), 32'(exp[63 - 8 * k -: 8]));
         chk($sformatf("%s_l%0d", tag, base + k), 32'(w[8]), 32'(k == last_k));
      end
   endtask

   initial begin
      int         n;
      logic [7:0] e;
      logic [8:0] w;
      out_ready = 1'b1;
      in_data = '0; in_idx = '0; in_data7 = '0; in_idx7 = '0;
      do_reset();

      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: one row, no backpressure
      send(0, 8'h10, 4'd0);
      send(0, 8'h20, 4'd3);
      wait_q(8);
      check_row("t1", 0, E_R0, -1);

      // 2: same row, random backpressure
      do_reset();
      send(0, 8'h10, 4'd0);
      send(0, 8'h20, 4'd3);
      for (int i = 0; i < 400 && q.size() < 8; i++) begin
         @(posedge clk);
         #1 out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      wait_q(8);
      check_row("t2", 0, E_R0, -1);

      // 3: in_valid held high through emission
      do_reset();
      send(0, 8'h10, 4'd0);
      send(0, 8'h20, 4'd3);
      in_valid = 1'b1; in_data = 8'h55; in_idx = 2'd1;
      @(negedge clk);
      #1 chk("t3_blocked", 32'(in_ready), 32'd0);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1 n++;
      end
      chk("t3_ready_after", 32'(in_ready), 32'd1);
      chk("t3_beats_at_ready", 32'(q.size()), 32'd8);
      @(posedge clk);
      #1 in_valid = 1'b0;

      // 4: two full frames, out_last on final beat only
      do_reset();
      for (int f = 0; f < 2; f++) begin
         send(0, 8'h10, 4'd0);
         send(0, 8'h20, 4'd3);
         send(0, 8'h30, 4'd1);
         send(0, 8'h40, 4'd2);
      end
      wait_q(32);
      check_row("t4f0r0", 0,  E_R0, -1);
      check_row("t4f0r1", 8,  E_R1, 7);
      check_row("t4f1r0", 16, E_R0, -1);
      check_row("t4f1r1", 24, E_R1, 7);

      // 5: asynchronous reset mid-row, then clean restart
      do_reset();
      send(0, 8'h10, 4'd0);
      send(0, 8'h20, 4'd3);
      wait_q(3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid_async", 32'(out_valid), 32'd0);
      chk("t5_ready_async", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      send(0, 8'h10, 4'd0);
      send(0, 8'h20, 4'd3);
      wait_q(8);
      check_row("t5", 0, E_R0, -1);

      // 6: placement of idx2/idx1 (nearest build replicates)
      do_reset();
      send(0, 8'h10, 4'd2);
      send(0, 8'h20, 4'd1);
      wait_q(8);
      check_row("t6", 0, E_R6, -1);

      // 7: 2 channels, 3x3 pool, idx 9 out of range
      do_reset();
      send(1, 8'hAA, 4'd4);
      send(1, 8'hBB, 4'd9);
      send(1, 8'hCC, 4'd0);
      send(1, 8'hDD, 4'd8);
      for (int i = 0; i < 400 && q7.size() < 36; i++) @(negedge clk);
      chk("t7_count", 32'(q7.size() >= 36), 32'd1);
      for (int k = 0; k < 36; k++) begin
`ifdef MAX_UNPOOL_NEAREST_EN
         case ({((k / 6) % 2 == 1), (k % 2 == 1)})
            2'b00:   e = 8'hAA;
            2'b01:   e = 8'hBB;
            2'b10:   e = 8'hCC;
            default: e = 8'hDD;
         endcase
`else
         e = (k == 14) ? 8'hAA : (k == 6) ? 8'hCC : (k == 35) ? 8'hDD : 8'h00;
`endif
         w = (k < q7.size()) ? q7[k] : 9'h1FF;
         chk($sformatf("t7_d%0d", k), 32'(w[7:0]), 32'(e));
         chk($sformatf("t7_l%0d", k), 32'(w[8]), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
